// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: 24-hour BCD timekeeper with a two-button set mode.
// Drives six BCD digits plus a per-digit blank mask that blinks the field
// being edited, paced by the video frame strobe.
//
// state | meaning
// RUN   | clock advances on tick_1hz, btn_inc ignored
// SET_H | hours selected, inc press bumps hours, hours digits blink
// SET_M | minutes selected, inc press bumps minutes, minutes digits blink
// SET_S | seconds selected, inc press bumps seconds, seconds digits blink

module clock_set_ctrl #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       frame_tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] h1,
    output logic [3:0] h0,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic [5:0] blank_mask,
    output logic       set_active
);

    typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} stateType;

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    stateType   state, stateNext;
    logic [7:0] hours, hoursNext;
    logic [7:0] minutes, minutesNext;
    logic [7:0] seconds, secondsNext;
    logic [7:0] blinkCnt, blinkCntNext;
    logic       blinkPhase, blinkPhaseNext;
    logic       modePrev, incPrev;
    logic       modePress, incPress;
    logic [5:0] maskNext;

    // Two-digit BCD increment wrapping 59 -> 00.
    function automatic logic [7:0] inc60(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) return 8'h00;
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Two-digit BCD increment wrapping 23 -> 00.
    function automatic logic [7:0] inc24(input logic [7:0] v);
        if (v == 8'h23) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign modePress = btn_mode & ~modePrev;
    assign incPress  = btn_inc & ~incPrev;

    // Next-state computation for the FSM, time fields and blink timer.
    always_comb begin
        stateNext      = state;
        hoursNext      = hours;
        minutesNext    = minutes;
        secondsNext    = seconds;
        blinkCntNext   = blinkCnt;
        blinkPhaseNext = blinkPhase;

        if (state == RUN) begin
            blinkCntNext   = 8'd0;
            blinkPhaseNext = 1'b0;
            if (tick_1hz) begin
                secondsNext = inc60(seconds);
                if (seconds == 8'h59) begin
                    minutesNext = inc60(minutes);
                    if (minutes == 8'h59) hoursNext = inc24(hours);
                end
            end
            if (modePress) stateNext = SET_H;
        end else if (modePress) begin
            // Mode wins over a coincident inc press.
            case (state)
                SET_H:   stateNext = SET_M;
                SET_M:   stateNext = SET_S;
                default: stateNext = RUN;
            endcase
            blinkCntNext   = 8'd0;
            blinkPhaseNext = 1'b0;
        end else if (incPress) begin
            // Editing keeps the field visible; overrides a coincident frame tick.
            case (state)
                SET_H:   hoursNext   = inc24(hours);
                SET_M:   minutesNext = inc60(minutes);
                default: secondsNext = inc60(seconds);
            endcase
            blinkCntNext   = 8'd0;
            blinkPhaseNext = 1'b0;
        end else if (frame_tick) begin
            if (blinkCnt == BLINK_LAST) begin
                blinkCntNext   = 8'd0;
                blinkPhaseNext = ~blinkPhase;
            end else begin
                blinkCntNext = blinkCnt + 8'd1;
            end
        end

        maskNext = 6'b000000;
        if (blinkPhaseNext) begin
            case (stateNext)
                SET_H:   maskNext = 6'b110000;
                SET_M:   maskNext = 6'b001100;
                SET_S:   maskNext = 6'b000011;
                default: maskNext = 6'b000000;
            endcase
        end
    end

    // State, time and output registers; button history resets high so a
    // button held through reset release is not taken as a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            hours      <= 8'h00;
            minutes    <= 8'h00;
            seconds    <= 8'h00;
            blinkCnt   <= 8'd0;
            blinkPhase <= 1'b0;
            modePrev   <= 1'b1;
            incPrev    <= 1'b1;
            blank_mask <= 6'b000000;
            set_active <= 1'b0;
        end else begin
            state      <= stateNext;
            hours      <= hoursNext;
            minutes    <= minutesNext;
            seconds    <= secondsNext;
            blinkCnt   <= blinkCntNext;
            blinkPhase <= blinkPhaseNext;
            modePrev   <= btn_mode;
            incPrev    <= btn_inc;
            blank_mask <= maskNext;
            set_active <= (stateNext != RUN);
        end
    end

    assign h1 = hours[7:4];
    assign h0 = hours[3:0];
    assign m1 = minutes[7:4];
    assign m0 = minutes[3:0];
    assign s1 = seconds[7:4];
    assign s0 = seconds[3:0];

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed testbench for clock_set_ctrl with a short blink period.

module tb_clock_set_ctrl;

    localparam int BF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] h1, h0, m1, m0, s1, s0;
    logic [5:0] blank_mask;
    logic       set_active;

    int checkCount = 0;
    int errorCount = 0;

    clock_set_ctrl #(.BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .frame_tick (frame_tick),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .h1         (h1),
        .h0         (h0),
        .m1         (m1),
        .m0         (m0),
        .s1         (s1),
        .s0         (s0),
        .blank_mask (blank_mask),
        .set_active (set_active)
    );

    always #5 clk = ~clk;

    wire [23:0] timeVal = {h1, h0, m1, m0, s1, s0};

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic pressMode();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        step();
    endtask

    task automatic pressInc();
        btn_inc = 1'b1;
        step();
        btn_inc = 1'b0;
        step();
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        step();
        checkVal("reset_time", timeVal, 24'h000000);
        checkVal("reset_mask", blank_mask, 6'b000000);
        checkVal("reset_set", set_active, 1'b0);

        for (int i = 0; i < 61; i++) tick();
        checkVal("run61_time", timeVal, 24'h000101);
        checkVal("run61_mask", blank_mask, 6'b000000);
        checkVal("run61_set", set_active, 1'b0);

        pressInc();
        checkVal("run_inc_ignored", timeVal, 24'h000101);

        pressMode();
        checkVal("seth_set", set_active, 1'b1);
        checkVal("seth_mask0", blank_mask, 6'b000000);
        for (int i = 0; i < BF - 1; i++) frame();
        checkVal("seth_blink_pre", blank_mask, 6'b000000);
        frame();
        checkVal("seth_blink_on", blank_mask, 6'b110000);
        for (int i = 0; i < BF; i++) frame();
        checkVal("seth_blink_off", blank_mask, 6'b000000);

        for (int i = 0; i < 25; i++) pressInc();
        checkVal("seth_inc25", timeVal, 24'h010101);
        for (int i = 0; i < 3; i++) tick();
        checkVal("seth_tick_ignored", timeVal, 24'h010101);
        for (int i = 0; i < 22; i++) pressInc();
        checkVal("seth_to23", timeVal, 24'h230101);

        pressMode();
        checkVal("setm_set", set_active, 1'b1);
        for (int i = 0; i < 58; i++) pressInc();
        checkVal("setm_to59", timeVal, 24'h235901);
        for (int i = 0; i < BF; i++) frame();
        checkVal("setm_blink_on", blank_mask, 6'b001100);
        btn_inc = 1'b1;
        step();
        checkVal("setm_wrap_mask", blank_mask, 6'b000000);
        checkVal("setm_wrap_time", timeVal, 24'h230001);
        btn_inc = 1'b0;
        step();
        btn_inc = 1'b1;
        repeat (100) step();
        btn_inc = 1'b0;
        step();
        checkVal("setm_held_once", timeVal, 24'h230101);
        for (int i = 0; i < 58; i++) pressInc();

        pressMode();
        for (int i = 0; i < 57; i++) pressInc();
        checkVal("sets_to58", timeVal, 24'h235958);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step();
        checkVal("mode_beats_inc_time", timeVal, 24'h235958);
        checkVal("mode_beats_inc_set", set_active, 1'b0);

        tick();
        checkVal("run_235959", timeVal, 24'h235959);
        tick();
        checkVal("run_rollover", timeVal, 24'h000000);

        tick_1hz = 1'b1;
        btn_mode = 1'b1;
        step();
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        checkVal("tick_mode_time", timeVal, 24'h000001);
        checkVal("tick_mode_set", set_active, 1'b1);
        step();
        pressMode();
        pressMode();
        for (int i = 0; i < BF; i++) frame();
        checkVal("sets_blink_on", blank_mask, 6'b000011);
        frame();
        frame();
        rst = 1'b1;
        btn_mode = 1'b1;
        step();
        checkVal("midrst_time", timeVal, 24'h000000);
        checkVal("midrst_mask", blank_mask, 6'b000000);
        checkVal("midrst_set", set_active, 1'b0);
        rst = 1'b0;
        repeat (5) step();
        checkVal("held_mode_no_press", set_active, 1'b0);
        btn_mode = 1'b0;
        step();

        pressMode();
        checkVal("after_release_set", set_active, 1'b1);
        for (int i = 0; i < BF - 1; i++) frame();
        btn_inc    = 1'b1;
        frame_tick = 1'b1;
        step();
        btn_inc    = 1'b0;
        frame_tick = 1'b0;
        checkVal("inc_frame_time", timeVal, 24'h010000);
        checkVal("inc_frame_mask", blank_mask, 6'b000000);
        for (int i = 0; i < BF - 1; i++) frame();
        checkVal("inc_frame_cnt_cleared", blank_mask, 6'b000000);
        frame();
        checkVal("inc_frame_blink_on", blank_mask, 6'b110000);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Timekeeping and time-set controller that produces the six BCD digits (h1,h0,m1,m0,s1,s0) consumed by the on-screen clock digit renderer.
- Runs a 24-hour BCD clock from a 1 Hz strobe.
- A two-button set-mode FSM selects a field (hours, minutes, seconds) and lets the user increment it.
- The selected field blinks through a per-digit blank mask, timed from the frame (vertical sync) strobe.

Parameters:
- BLINK_FRAMES, 30, number of frame_tick pulses per blink half-period (on or off); legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- tick_1hz  input  1  one-cycle strobe, once per second.
- frame_tick  input  1  one-cycle strobe, once per video frame.
- btn_mode  input  1  debounced level of the mode button; 1 = pressed.
- btn_inc  input  1  debounced level of the increment button; 1 = pressed.
- h1  output  4  hours tens, BCD 0..2.
- h0  output  4  hours units, BCD 0..9 (0..3 when h1=2).
- m1  output  4  minutes tens, BCD 0..5.
- m0  output  4  minutes units, BCD 0..9.
- s1  output  4  seconds tens, BCD 0..5.
- s0  output  4  seconds units, BCD 0..9.
- blank_mask  output  6  1 = blank that digit. Bit order is [5]=h1, [4]=h0, [3]=m1, [2]=m0, [1]=s1, [0]=s0.
- set_active  output  1  1 while in any SET state.

Behaviour:
- All outputs are registered. Updates appear on the cycle after the triggering input edge.
- Reset values:
  - Digits all 0 (00:00:00).
  - State RUN, blank_mask 0, set_active 0.
  - Blink counter 0, blink phase 0.
  - Button history registers are set to 1, so a button held through reset release is not a press.
- Press detection: press = btn & ~btn_prev, with btn_prev registered each cycle. A held button produces exactly one press.
- FSM states: RUN, SET_H, SET_M, SET_S.
  - A mode press advances RUN -> SET_H -> SET_M -> SET_S -> RUN.
  - Any transition clears the blink counter and phase.
- RUN state:
  - tick_1hz increments the seconds field.
  - s0 wraps 9->0 and carries to s1. s1:s0 wraps 59->00 and carries to minutes.
  - Minutes use the same rule and carry into hours.
  - Hours wrap 23->00. 23:59:59 + tick gives 00:00:00 in a single cycle.
  - btn_inc is ignored.
- SET states:
  - tick_1hz is ignored and discarded (not queued).
  - An inc press increments only the selected field, with its own wrap: hours 23->00, minutes and seconds 59->00.
  - No carry into the neighbouring field.
  - An inc press forces blink phase 0 (visible) and clears the blink counter.
- Simultaneous events:
  - tick_1hz and mode press in RUN: the tick is applied and the state moves to SET_H in the same cycle.
  - Mode and inc press together in a SET state: the mode press wins and the inc is dropped.
  - Inc press and frame_tick together: the inc reset of the blink counter and phase wins.
- Blink:
  - In SET states, each frame_tick increments the counter.
  - When the counter reaches BLINK_FRAMES-1 on a frame_tick, it returns to 0 and the phase toggles.
  - blank_mask has both bits of the selected field set when phase=1 and is 0 otherwise. SET_H gives 6'b110000, SET_M gives 6'b001100, SET_S gives 6'b000011.
  - In RUN, blank_mask is 0 and the counter is held at 0.
- set_active is 1 exactly in SET_H, SET_M and SET_S.
- Reset mid-operation (any state, mid-blink) returns all registers to their reset values on the next edge.
- Digits never leave legal BCD ranges. No illegal value is reachable from reset.

Test Plan:
- Reset, then 61 tick_1hz pulses -> digits 00:01:01, blank_mask 0, set_active 0.
- Load 23:59:58 (via set mode), return to RUN, 2 ticks -> 23:59:59 then 00:00:00; each value visible one cycle after its tick.
- Mode press once -> SET_H and set_active=1. BLINK_FRAMES frame_ticks -> blank_mask 6'b110000; BLINK_FRAMES more -> 6'b000000.
- In SET_H, 25 inc presses from 00 -> hours 01 (wraps through 23->00), minutes and seconds unchanged. Ticks applied during SET_H -> seconds unchanged.
- In SET_M at 59, inc press -> minutes 00, hours unchanged, blank_mask 0 immediately. btn_inc held for 100 cycles -> exactly one increment.
- btn_mode held high through reset release -> state stays RUN. Assert rst mid-blink in SET_S -> 00:00:00, RUN, blank_mask 0 on the next cycle.
